mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control FSM for the ARM core. It sequences the shared datapath (register file, ALU, shifter, unified instruction/data memory) over several cycles per instruction. It drives the mux selects and the write enables. The combinational instruction decoder still produces ALUControl, FlagW, shift controls and immediate selects, using the ALUOp and linkSelect issued here. Memory accesses use a ready handshake, so wait states stall the FSM.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Op  in  2  instruction class: 00 data-processing, 01 LDR/STR, 10 B, 11 BL.
- Funct  in  6  Funct[5] = I bit, Funct[4:1] = DP opcode, Funct[0] = S / L bit.
- Rd  in  4  destination register field.
- CondEx  in  1  condition passes, valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- IRWrite  out  1  load the instruction register.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ALUSrcA  out  1  ALU A select: 0 = Rn, 1 = PC.
- ALUSrcB  out  2  ALU B select: 0 = shifted Rm, 1 = ExtImm, 2 = constant 4.
- ResultSrc  out  2  result select: 0 = ALUOut, 1 = ReadData, 2 = ALUResult, 3 = PC.
- PCWrite  out  1  PC load enable.
- RegWrite  out  1  register-file write enable.
- MemWrite  out  1  memory write strobe.
- mem_req  out  1  memory access request.
- ALUOp  out  1  ALU decoder enable; 0 forces ADD.
- linkSelect  out  1  register-file write address = R14.
- instr_done  out  1  one-cycle pulse on an instruction's final cycle.
- state  out  4  current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, LINK 10. Codes 11–15 are illegal and go to FETCH on the next edge with all outputs 0.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ResultSrc=2.
  - IRWrite and PCWrite equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=1, ALUSrcB=2, ResultSrc=2. All write enables 0.
- From DECODE:
  - Op 01 → MEMADR.
  - Op 00 with Funct[5]=0 → EXECR; with Funct[5]=1 → EXECI.
  - Op 10 → BRANCH.
  - Op 11 → LINK.
- MEMADR: ALUSrcA=0, ALUSrcB=1, ALUOp=0. Goes to MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: mem_req=1, AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=1, RegWrite=CondEx, PCWrite=CondEx & (Rd==15). instr_done=1. Then FETCH.
- MEMWR: mem_req=1, AdrSrc=1, MemWrite=CondEx, held while waiting. Leaves when mem_ready=1, with instr_done=1, then FETCH.
  - If CondEx=0: mem_req=0 and the FSM goes straight to FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=0, ALUOp=1. Then ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=1, ALUOp=1. Then ALUWB.
- ALUWB: ResultSrc=0, ALUOp=1, instr_done=1. Then FETCH.
  - RegWrite = CondEx & ~(Funct[4:3]==2'b10), so TST/TEQ/CMP/CMN never write.
  - PCWrite = RegWrite & (Rd==15).
- LINK: ResultSrc=3 (PC, already PC+4), linkSelect=1, RegWrite=CondEx. Then BRANCH.
- BRANCH: ALUSrcA=0, ALUSrcB=1, ResultSrc=2, PCWrite=CondEx, instr_done=1. Then FETCH.
- Any output not listed for a state is 0 in that state.

## Timing
- Outputs are a combinational decode of the state register plus CondEx and mem_ready; there are no registered outputs.
- Reset (asynchronous assert, synchronous deassert at the consumer):
  - state=FETCH immediately.
  - While reset_n=0, IRWrite, PCWrite, RegWrite, MemWrite, mem_req and instr_done are forced to 0.
- Cycle counts with zero wait states:
  - DP: 4 (F, D, E, WB).
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - BL: 4.
- Each cycle mem_ready is low adds one cycle in FETCH, MEMRD or MEMWR.
- Handshake: the address and MemWrite stay stable while mem_req=1 and mem_ready=0. mem_ready is ignored when mem_req=0.
- Reset asserted mid-instruction abandons the instruction; no writes occur after reset_n falls.

## Test plan
- Reset: hold reset_n=0 with mem_ready=1 → state=0, IRWrite=0, PCWrite=0. Release → first edge goes to DECODE.
- ADD R1,R2,#5 (Op=00, Funct=101000, CondEx=1), mem_ready=1 → states 0,1,7,8. RegWrite=1 only in cycle 4, instr_done=1 in cycle 4.
- LDR with 2 wait cycles in MEMRD → states 0,1,2,3,3,3,4. RegWrite in MEMWB with ResultSrc=1.
- STR with CondEx=0 → states 0,1,2,5,0. MemWrite and mem_req never 1 in MEMWR.
- BL (Op=11) → states 0,1,10,9. RegWrite=1 with linkSelect=1 in LINK; PCWrite=1 in BRANCH.
- CMP (Funct=010101) with Rd=15 → RegWrite=0 and PCWrite=0 in ALUWB. Force state=13 → next state 0.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences fetch, decode, memory, ALU and branch
// steps over the shared datapath, stalling on memory wait states.
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    LINK   = 4'd10
  } state_t;
endpackage

module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       mem_req,
  output logic       ALUOp,
  output logic       linkSelect,
  output logic       instr_done,
  output logic [3:0] state
);

  state_t state_r;
  state_t state_n;

  logic irw, pcw, rw, mw, mr, done;
  logic rd_pc;
  logic unused_funct;

  assign rd_pc        = (Rd == 4'd15);
  assign unused_funct = ^Funct[2:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= FETCH;
    else          state_r <= state_n;
  end

  always_comb begin
    state_n    = FETCH;
    irw        = 1'b0;
    pcw        = 1'b0;
    rw         = 1'b0;
    mw         = 1'b0;
    mr         = 1'b0;
    done       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'd0;
    ResultSrc  = 2'd0;
    ALUOp      = 1'b0;
    linkSelect = 1'b0;
    case (state_r)
      FETCH: begin
        mr        = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        irw       = mem_ready;
        pcw       = mem_ready;
        state_n   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        unique case (Op)
          2'b00:   state_n = Funct[5] ? EXECI : EXECR;
          2'b01:   state_n = MEMADR;
          2'b10:   state_n = BRANCH;
          default: state_n = LINK;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'd1;
        state_n = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mr      = 1'b1;
        AdrSrc  = 1'b1;
        state_n = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ResultSrc = 2'd1;
        rw        = CondEx;
        pcw       = CondEx & rd_pc;
        done      = 1'b1;
      end
      MEMWR: begin
        // A failed condition skips the bus cycle entirely.
        AdrSrc  = 1'b1;
        mr      = CondEx;
        mw      = CondEx;
        done    = ~CondEx | mem_ready;
        state_n = (CondEx & ~mem_ready) ? MEMWR : FETCH;
      end
      EXECR: begin
        ALUOp   = 1'b1;
        state_n = ALUWB;
      end
      EXECI: begin
        ALUSrcB = 2'd1;
        ALUOp   = 1'b1;
        state_n = ALUWB;
      end
      ALUWB: begin
        ALUOp = 1'b1;
        done  = 1'b1;
        rw    = CondEx & (Funct[4:3] != 2'b10);
        pcw   = CondEx & (Funct[4:3] != 2'b10) & rd_pc;
      end
      LINK: begin
        ResultSrc  = 2'd3;
        linkSelect = 1'b1;
        rw         = CondEx;
        state_n    = BRANCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'd1;
        ResultSrc = 2'd2;
        pcw       = CondEx;
        done      = 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end

  assign IRWrite    = reset_n & irw;
  assign PCWrite    = reset_n & pcw;
  assign RegWrite   = reset_n & rw;
  assign MemWrite   = reset_n & mw;
  assign mem_req    = reset_n & mr;
  assign instr_done = reset_n & done;
  assign state      = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: state walks and per-state
// control outputs for DP, LDR, STR, B/BL, reset and illegal states.
module tb_mc_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
  logic       mem_ready;
  logic       IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc;
  logic       PCWrite, RegWrite, MemWrite, mem_req;
  logic       ALUOp, linkSelect, instr_done;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct),
    .Rd(Rd), .CondEx(CondEx), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .mem_req(mem_req), .ALUOp(ALUOp),
    .linkSelect(linkSelect), .instr_done(instr_done),
    .state(state)
  );

  always #5 clk = ~clk;

  // {IRWrite,PCWrite,RegWrite,MemWrite,mem_req,instr_done}
  wire [5:0] sb = {IRWrite, PCWrite, RegWrite,
                   MemWrite, mem_req, instr_done};
  // {AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,linkSelect}
  wire [7:0] mx = {AdrSrc, ALUSrcA, ALUSrcB,
                   ResultSrc, ALUOp, linkSelect};

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag,
                      input logic [3:0] st,
                      input logic [5:0] s);
    #1;
    chk({tag, "_state"}, 8'(state), 8'(st));
    chk({tag, "_strobes"}, 8'(sb), 8'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; CondEx = 1'b1;
    Op = 2'b00; Funct = 6'b0; Rd = 4'd0;
    repeat (3) @(negedge clk);
    look("rst", 4'd0, 6'b000000);

    // ADD R1,R2,#5
    reset_n = 1'b1; Funct = 6'b101000; Rd = 4'd1;
    look("add_f", 4'd0, 6'b110010);
    chk("add_f_mux", mx, 8'b01101000);
    @(negedge clk); look("add_d", 4'd1, 6'b000000);
    @(negedge clk); look("add_e", 4'd7, 6'b000000);
    chk("add_e_mux", mx, 8'b00010010);
    @(negedge clk); look("add_wb", 4'd8, 6'b001001);
    chk("add_wb_mux", mx, 8'b00000010);

    // LDR R3 with two wait states in MEMRD
    @(negedge clk);
    Op = 2'b01; Funct = 6'b000001; Rd = 4'd3;
    look("ldr_f", 4'd0, 6'b110010);
    @(negedge clk); look("ldr_d", 4'd1, 6'b000000);
    @(negedge clk); look("ldr_a", 4'd2, 6'b000000);
    chk("ldr_a_mux", mx, 8'b00010000);
    @(negedge clk); mem_ready = 1'b0;
    look("ldr_r0", 4'd3, 6'b000010);
    chk("ldr_r0_mux", mx, 8'b10000000);
    @(negedge clk); look("ldr_r1", 4'd3, 6'b000010);
    @(negedge clk); mem_ready = 1'b1;
    look("ldr_r2", 4'd3, 6'b000010);
    @(negedge clk); look("ldr_wb", 4'd4, 6'b001001);
    chk("ldr_wb_mux", mx, 8'b00000100);

    // STR with failed condition, memory not ready in MEMWR
    @(negedge clk);
    Funct = 6'b000000; CondEx = 1'b0;
    look("strn_f", 4'd0, 6'b110010);
    @(negedge clk); look("strn_d", 4'd1, 6'b000000);
    @(negedge clk); look("strn_a", 4'd2, 6'b000000);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("strn_w_state", 8'(state), 8'd5);
    chk("strn_w_mw_mr", 8'({MemWrite, mem_req}), 8'd0);
    @(negedge clk); look("strn_next", 4'd0, 6'b000010);

    // STR with one wait state
    mem_ready = 1'b1; CondEx = 1'b1;
    @(negedge clk); look("str_d", 4'd1, 6'b000000);
    @(negedge clk); look("str_a", 4'd2, 6'b000000);
    @(negedge clk); mem_ready = 1'b0;
    look("str_w0", 4'd5, 6'b000110);
    @(negedge clk); mem_ready = 1'b1;
    look("str_w1", 4'd5, 6'b000111);

    // BL
    @(negedge clk); Op = 2'b11;
    look("bl_f", 4'd0, 6'b110010);
    @(negedge clk); look("bl_d", 4'd1, 6'b000000);
    @(negedge clk); look("bl_l", 4'd10, 6'b001000);
    chk("bl_l_mux", mx, 8'b00001101);
    @(negedge clk); look("bl_b", 4'd9, 6'b010001);
    chk("bl_b_mux", mx, 8'b00011000);

    // CMP with Rd=15: flags only, no write
    @(negedge clk);
    Op = 2'b00; Funct = 6'b010101; Rd = 4'd15;
    look("cmp_f", 4'd0, 6'b110010);
    @(negedge clk); look("cmp_d", 4'd1, 6'b000000);
    @(negedge clk); look("cmp_e", 4'd6, 6'b000000);
    chk("cmp_e_mux", mx, 8'b00000010);
    @(negedge clk); look("cmp_wb", 4'd8, 6'b000001);

    // MOV PC (Rd=15) writes PC
    @(negedge clk); Funct = 6'b111010;
    @(negedge clk); @(negedge clk);
    @(negedge clk); look("movpc_wb", 4'd8, 6'b011001);

    // Reset mid-store abandons it at once
    @(negedge clk); Op = 2'b01; Funct = 6'b000000;
    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_ready = 1'b0;
    look("rstm_w", 4'd5, 6'b000110);
    #2 reset_n = 1'b0;
    look("rstm", 4'd0, 6'b000000);
    @(negedge clk); reset_n = 1'b1;
    look("rstm_rel", 4'd0, 6'b000010);

    // Illegal state 13: outputs zero, recovers to FETCH
    force dut.state_r = state_t'(4'd13);
    look("ill", 4'd13, 6'b000000);
    chk("ill_mux", mx, 8'd0);
    release dut.state_r;
    @(negedge clk); #1;
    chk("ill_next", 8'(state), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
